keypad_debounce_queue: RTL and testbench

//  Downstream consumer of the keypad scan FSM's DATA[3:0]/PRESS outputs.
//  - Debounces each keypress; emits exactly one key event per physical press.
//  - Queues events in a small FWFT FIFO and interrupts the MCU.
//  - The MCU reads the head code and pops with RD, decoupling key timing from software.

---
 rtl/keypad_pkg.sv | 19 +
 rtl/kp_sync_fifo.sv | 66 ++++++
 rtl/keypad_debounce_queue.sv | 120 ++++++++++++
 tb/tb_keypad_debounce_queue.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad debounce/queue slice.
// Key codes 0..11 are real keys; 13 is the scan FSM's idle code.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CHECK,
    ST_HELD,
    ST_RELEASE
  } deb_state_t;

  localparam logic [3:0] KP_NO_KEY  = 4'd13;
  localparam logic [3:0] KP_MAX_KEY = 4'd11;

  function automatic logic is_key(logic [3:0] d);
    return (d <= KP_MAX_KEY) && (d != KP_NO_KEY);
  endfunction

endpackage

// File: rtl/kp_sync_fifo.sv
// First-word-fall-through FIFO with exact occupancy count.
// Head data reads as zero while empty.
module kp_sync_fifo #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           din_i,
  output logic [WIDTH-1:0]           dout_o,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_q, wr_d;
  logic [AW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign count_o = cnt_q;
  assign dout_o  = empty_o ? '0 : mem_q[rd_q];

  // A pop on the same cycle frees the slot a full-queue push needs.
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (do_push) wr_d = wr_q + AW'(1);
    if (do_pop)  rd_d = rd_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (do_push) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/keypad_debounce_queue.sv
// Debounces scan-FSM keypresses into single events, queues them
// for the MCU and raises a one-cycle interrupt per accepted key.
module keypad_debounce_queue
  import keypad_pkg::*;
#(
  parameter int DEB_CYCLES = 16,
  parameter int DEPTH      = 4
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       PRESS,
  input  logic [3:0]                 DATA,
  input  logic                       RD,
  output logic [3:0]                 KEY_CODE,
  output logic                       KEY_VALID,
  output logic                       INTR,
  output logic                       OVF,
  output logic [$clog2(DEPTH+1)-1:0] COUNT
);

  localparam int CW = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEB_CYCLES - 1);

  deb_state_t    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [3:0]    cand_q, cand_d;
  logic          intr_q;
  logic          ovf_q;
  logic          push;
  logic          full;
  logic          empty;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cand_d  = cand_q;
    push    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (PRESS && is_key(DATA)) begin
          cand_d  = DATA;
          cnt_d   = CW'(1);
          state_d = ST_CHECK;
        end
      end
      ST_CHECK: begin
        if (PRESS && (DATA == cand_q)) begin
          if (cnt_q == LAST) begin
            push    = 1'b1;
            cnt_d   = '0;
            state_d = ST_HELD;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end else begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end
      end
      ST_HELD: begin
        if (!PRESS) begin
          cnt_d   = CW'(1);
          state_d = ST_RELEASE;
        end
      end
      ST_RELEASE: begin
        // Any press while releasing is bounce on the same key.
        if (PRESS) begin
          cnt_d   = '0;
          state_d = ST_HELD;
        end else if (cnt_q == LAST) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      cand_q  <= '0;
      intr_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cand_q  <= cand_d;
      intr_q  <= push;
      if (push && full && !RD) ovf_q <= 1'b1;
    end
  end

  kp_sync_fifo #(
    .WIDTH(4),
    .DEPTH(DEPTH)
  ) u_fifo (
    .CLK    (CLK),
    .RST    (RST),
    .push_i (push),
    .pop_i  (RD),
    .din_i  (cand_q),
    .dout_o (KEY_CODE),
    .full_o (full),
    .empty_o(empty),
    .count_o(COUNT)
  );

  assign KEY_VALID = !empty;
  assign INTR      = intr_q;
  assign OVF       = ovf_q;

endmodule

// File: tb/tb_keypad_debounce_queue.sv
// Scoreboard bench: stimulus queues expected INTR cycles and read
// codes; a negedge monitor pops and compares as the DUT presents them.
module tb_keypad_debounce_queue;

  localparam int DEB = 4;
  localparam int DEP = 4;

  logic       CLK = 1'b0;
  logic       RST;
  logic       PRESS;
  logic [3:0] DATA;
  logic       RD;
  logic [3:0] KEY_CODE;
  logic       KEY_VALID;
  logic       INTR;
  logic       OVF;
  logic [2:0] COUNT;

  keypad_debounce_queue #(
    .DEB_CYCLES(DEB),
    .DEPTH(DEP)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .PRESS    (PRESS),
    .DATA     (DATA),
    .RD       (RD),
    .KEY_CODE (KEY_CODE),
    .KEY_VALID(KEY_VALID),
    .INTR     (INTR),
    .OVF      (OVF),
    .COUNT    (COUNT)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk = 0;
  int n_fail = 0;
  int exp_intr[$];
  int exp_code[$];
  bit pat [7] = '{1, 1, 0, 1, 1, 1, 1};

  task automatic chk(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge CLK) begin
    if (INTR === 1'b1) begin
      if (exp_intr.size() == 0) chk("intr_unexpected", cyc, -1);
      else chk("intr_cycle", cyc, exp_intr.pop_front());
    end
    if (RST === 1'b0 && RD === 1'b1 && KEY_VALID === 1'b1) begin
      if (exp_code.size() == 0) chk("read_unexpected", int'(KEY_CODE), -1);
      else chk("read_code", int'(KEY_CODE), exp_code.pop_front());
    end
  end

  task automatic step(int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic key(logic [3:0] d, int hi, int lo, bit acc, bit q);
    DATA  = d;
    PRESS = 1'b1;
    if (acc) exp_intr.push_back(cyc + DEB);
    if (q) exp_code.push_back(int'(d));
    step(hi);
    PRESS = 1'b0;
    step(lo);
  endtask

  task automatic rd(int n);
    RD = 1'b1;
    step(n);
    RD = 1'b0;
  endtask

  task automatic outs(string t, int kv, int kc, int cnt, int ovf);
    @(negedge CLK);
    chk({t, "_valid"}, int'(KEY_VALID), kv);
    chk({t, "_code"}, int'(KEY_CODE), kc);
    chk({t, "_count"}, int'(COUNT), cnt);
    chk({t, "_ovf"}, int'(OVF), ovf);
  endtask

  int c0;

  initial begin
    RST   = 1'b1;
    PRESS = 1'b0;
    RD    = 1'b0;
    DATA  = 4'd13;
    step(3);
    outs("reset", 0, 0, 0, 0);
    chk("reset_intr", int'(INTR), 0);
    RST = 1'b0;
    step(1);

    // clean press of 5
    key(4'd5, 10, 10, 1, 1);
    outs("t1", 1, 5, 1, 0);
    rd(1);
    outs("t1_drained", 0, 0, 0, 0);

    // bouncy press of 7
    DATA = 4'd7;
    c0 = cyc;
    exp_intr.push_back(c0 + 7);
    exp_code.push_back(7);
    for (int i = 0; i < 7; i++) begin
      PRESS = pat[i];
      step(1);
    end
    PRESS = 1'b0;
    step(8);
    outs("t2", 1, 7, 1, 0);
    rd(1);

    // codes above 11 never start a debounce
    key(4'd12, 8, 2, 0, 0);
    key(4'd13, 8, 2, 0, 0);
    outs("t_inval", 0, 0, 0, 0);

    // code change mid-check
    c0 = cyc;
    DATA  = 4'd3;
    PRESS = 1'b1;
    step(2);
    DATA = 4'd8;
    exp_intr.push_back(c0 + 7);
    exp_code.push_back(8);
    step(8);
    PRESS = 1'b0;
    step(6);
    outs("t3", 1, 8, 1, 0);
    rd(1);

    // overflow: fifth key dropped, INTR still fires
    key(4'd1, 5, 5, 1, 1);
    key(4'd2, 5, 5, 1, 1);
    key(4'd3, 5, 5, 1, 1);
    key(4'd4, 5, 5, 1, 1);
    key(4'd6, 5, 5, 1, 0);
    outs("t4_full", 1, 1, 4, 1);
    rd(4);
    outs("t4_empty", 0, 0, 0, 1);
    rd(1);
    outs("t4_pop_empty", 0, 0, 0, 1);

    // full queue, push coincides with pop
    RST = 1'b1;
    step(1);
    RST = 1'b0;
    step(1);
    outs("t5_reset", 0, 0, 0, 0);
    key(4'd0, 5, 5, 1, 1);
    key(4'd10, 5, 5, 1, 1);
    key(4'd11, 5, 5, 1, 1);
    key(4'd2, 5, 5, 1, 1);
    c0 = cyc;
    DATA  = 4'd9;
    PRESS = 1'b1;
    exp_intr.push_back(c0 + 4);
    exp_code.push_back(9);
    step(3);
    RD = 1'b1;
    step(1);
    RD = 1'b0;
    outs("t5", 1, 10, 4, 0);
    PRESS = 1'b0;
    step(6);
    rd(4);
    outs("t5_empty", 0, 0, 0, 0);

    // push on empty with pop in same cycle
    c0 = cyc;
    DATA  = 4'd4;
    PRESS = 1'b1;
    exp_intr.push_back(c0 + 4);
    exp_code.push_back(4);
    step(3);
    RD = 1'b1;
    step(1);
    RD = 1'b0;
    outs("t5b", 1, 4, 1, 0);
    PRESS = 1'b0;
    step(6);
    rd(1);

    // reset mid-check with two keys queued
    key(4'd1, 5, 5, 1, 0);
    key(4'd2, 5, 5, 1, 0);
    outs("t6_pre", 1, 1, 2, 0);
    DATA  = 4'd3;
    PRESS = 1'b1;
    step(2);
    RST = 1'b1;
    exp_intr.push_back(cyc + 5);
    exp_code.push_back(3);
    step(1);
    RST = 1'b0;
    outs("t6_rst", 0, 0, 0, 0);
    chk("t6_rst_intr", int'(INTR), 0);
    step(8);
    PRESS = 1'b0;
    step(6);
    outs("t6_after", 1, 3, 1, 0);
    rd(1);
    step(2);

    chk("intr_pending", exp_intr.size(), 0);
    chk("read_pending", exp_code.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
